// File: rtl/vga_timing_receiver.sv
// vga_timing_receiver
// Receiving end of a VGA pixel stream. Recovers pixel coordinates from the
// Blank/Hsync/Vsync timing, checks the line width and frame height against
// the expected geometry, and only marks pixels valid once it has locked on.
module vga_timing_receiver #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int COORD_W  = 11
) (
    input  logic               Clock50Mhz,
    input  logic               Reset,
    input  logic               PixEn,
    input  logic               Blank,
    input  logic               Hsync,
    input  logic               Vsync,
    input  logic [7:0]         R,
    input  logic [7:0]         G,
    input  logic [7:0]         B,
    output logic [COORD_W-1:0] CoordX,
    output logic [COORD_W-1:0] CoordY,
    output logic [7:0]         ROut,
    output logic [7:0]         GOut,
    output logic [7:0]         BOut,
    output logic               PixelValid,
    output logic               FrameStart,
    output logic               Locked,
    output logic               SyncError
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [COORD_W-1:0] H_CNT     = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_CNT     = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] CNT_MAX   = '1;
    localparam logic [COORD_W-1:0] CNT_ONE   = COORD_W'(1);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] xcnt_q, xcnt_d;
    logic [COORD_W-1:0] ycnt_q, ycnt_d;
    logic               prev_blank_q, prev_blank_d;
    logic               prev_hsync_q, prev_hsync_d;
    logic               prev_vsync_q, prev_vsync_d;
    logic [COORD_W-1:0] coord_x_q, coord_x_d;
    logic [COORD_W-1:0] coord_y_q, coord_y_d;
    logic [7:0]         r_q, r_d;
    logic [7:0]         g_q, g_d;
    logic [7:0]         b_q, b_d;
    logic               pixel_valid_q, pixel_valid_d;
    logic               frame_start_q, frame_start_d;
    logic               locked_q, locked_d;
    logic               sync_error_q, sync_error_d;

    logic               blank_fall;
    logic               hsync_fall;
    logic               vsync_fall;
    logic               width_err;
    logic               height_ok;
    logic [COORD_W-1:0] height;

    // Falling edges are taken between consecutive PixEn samples only.
    always_comb begin
        blank_fall = PixEn & prev_blank_q & ~Blank;
        hsync_fall = PixEn & prev_hsync_q & ~Hsync;
        vsync_fall = PixEn & prev_vsync_q & ~Vsync;
        width_err  = blank_fall & (xcnt_q != H_CNT);
    end

    // Coordinate counters; line end is applied before the frame boundary so a
    // coincident Blank/Vsync fall counts the closing line in the height.
    always_comb begin
        xcnt_d       = xcnt_q;
        ycnt_d       = ycnt_q;
        height       = ycnt_q;
        prev_blank_d = prev_blank_q;
        prev_hsync_d = prev_hsync_q;
        prev_vsync_d = prev_vsync_q;
        if (PixEn) begin
            prev_blank_d = Blank;
            prev_hsync_d = Hsync;
            prev_vsync_d = Vsync;
            if (Blank && (xcnt_q != CNT_MAX)) begin
                xcnt_d = xcnt_q + CNT_ONE;
            end
            if (hsync_fall) begin
                xcnt_d = '0;
            end
            if (blank_fall) begin
                xcnt_d = '0;
                if (ycnt_q != CNT_MAX) begin
                    ycnt_d = ycnt_q + CNT_ONE;
                end
            end
            height = ycnt_d;
            if (vsync_fall) begin
                xcnt_d = '0;
                ycnt_d = '0;
            end
        end
        height_ok = (height == V_CNT);
    end

    // Lock FSM: a full frame of correct geometry between two Vsync falls locks.
    always_comb begin
        state_d      = state_q;
        sync_error_d = 1'b0;
        if (PixEn) begin
            case (state_q)
                ST_SEARCH: begin
                    if (vsync_fall) begin
                        state_d = ST_ALIGN;
                    end
                end
                ST_ALIGN, ST_LOCKED: begin
                    if (width_err) begin
                        state_d      = ST_SEARCH;
                        sync_error_d = 1'b1;
                    end else if (vsync_fall) begin
                        if (height_ok) begin
                            state_d = ST_LOCKED;
                        end else begin
                            state_d      = ST_SEARCH;
                            sync_error_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    // Output staging: pulses default low, everything else holds between samples.
    always_comb begin
        pixel_valid_d = 1'b0;
        frame_start_d = 1'b0;
        coord_x_d     = coord_x_q;
        coord_y_d     = coord_y_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        locked_d      = locked_q;
        if (PixEn) begin
            locked_d = (state_d == ST_LOCKED);
            if (Blank) begin
                coord_x_d     = xcnt_q;
                coord_y_d     = ycnt_q;
                r_d           = R;
                g_d           = G;
                b_d           = B;
                pixel_valid_d = (state_q == ST_LOCKED);
                frame_start_d = (state_q == ST_LOCKED) &&
                                (xcnt_q == '0) && (ycnt_q == '0);
            end
        end
    end

    // State register for the lock FSM.
    always_ff @(posedge Clock50Mhz or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, edge-history and output registers.
    always_ff @(posedge Clock50Mhz or negedge Reset) begin
        if (!Reset) begin
            xcnt_q        <= '0;
            ycnt_q        <= '0;
            prev_blank_q  <= 1'b1;
            prev_hsync_q  <= 1'b1;
            prev_vsync_q  <= 1'b1;
            coord_x_q     <= '0;
            coord_y_q     <= '0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            pixel_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_error_q  <= 1'b0;
        end else begin
            xcnt_q        <= xcnt_d;
            ycnt_q        <= ycnt_d;
            prev_blank_q  <= prev_blank_d;
            prev_hsync_q  <= prev_hsync_d;
            prev_vsync_q  <= prev_vsync_d;
            coord_x_q     <= coord_x_d;
            coord_y_q     <= coord_y_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            pixel_valid_q <= pixel_valid_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            sync_error_q  <= sync_error_d;
        end
    end

    assign CoordX     = coord_x_q;
    assign CoordY     = coord_y_q;
    assign ROut       = r_q;
    assign GOut       = g_q;
    assign BOut       = b_q;
    assign PixelValid = pixel_valid_q;
    assign FrameStart = frame_start_q;
    assign Locked     = locked_q;
    assign SyncError  = sync_error_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// tb_vga_timing_receiver
// Drives small VGA-like frames (8x4) with directed geometry faults and
// randomized pixel data / PixEn gaps, comparing every cycle against a
// sample-by-sample reference model of the receiver's rules.
module tb_vga_timing_receiver;

    localparam int H_ACT = 8;
    localparam int V_ACT = 4;
    localparam int CW    = 11;
    localparam int MAXC  = (1 << CW) - 1;

    logic          Clock50Mhz;
    logic          Reset;
    logic          PixEn;
    logic          Blank;
    logic          Hsync;
    logic          Vsync;
    logic [7:0]    R;
    logic [7:0]    G;
    logic [7:0]    B;
    logic [CW-1:0] CoordX;
    logic [CW-1:0] CoordY;
    logic [7:0]    ROut;
    logic [7:0]    GOut;
    logic [7:0]    BOut;
    logic          PixelValid;
    logic          FrameStart;
    logic          Locked;
    logic          SyncError;

    int checks   = 0;
    int failures = 0;

    int pv_seen = 0;
    int fs_seen = 0;
    int se_seen = 0;

    int gap_min = 1;
    int gap_max = 1;

    // Reference model state: position within the line/frame and lock progress.
    int m_x;
    int m_y;
    bit m_pb;
    bit m_ph;
    bit m_pvs;
    bit m_aligned;
    bit m_locked;

    int exp_cx;
    int exp_cy;
    int exp_r;
    int exp_g;
    int exp_b;
    bit exp_pv;
    bit exp_fs;
    bit exp_se;
    bit exp_lock;

    vga_timing_receiver #(
        .H_ACTIVE (H_ACT),
        .V_ACTIVE (V_ACT),
        .COORD_W  (CW)
    ) dut (
        .Clock50Mhz (Clock50Mhz),
        .Reset      (Reset),
        .PixEn      (PixEn),
        .Blank      (Blank),
        .Hsync      (Hsync),
        .Vsync      (Vsync),
        .R          (R),
        .G          (G),
        .B          (B),
        .CoordX     (CoordX),
        .CoordY     (CoordY),
        .ROut       (ROut),
        .GOut       (GOut),
        .BOut       (BOut),
        .PixelValid (PixelValid),
        .FrameStart (FrameStart),
        .Locked     (Locked),
        .SyncError  (SyncError)
    );

    // 100 MHz-style free running clock.
    initial begin
        Clock50Mhz = 1'b0;
        forever #5 Clock50Mhz = ~Clock50Mhz;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0;
        m_pb = 1'b1; m_ph = 1'b1; m_pvs = 1'b1;
        m_aligned = 1'b0; m_locked = 1'b0;
        exp_cx = 0; exp_cy = 0; exp_r = 0; exp_g = 0; exp_b = 0;
        exp_pv = 1'b0; exp_fs = 1'b0; exp_se = 1'b0; exp_lock = 1'b0;
    endtask

    // One accepted sample, processed in the order: pixel, hsync, line end, frame end.
    task automatic model_step(input bit bl, input bit hs, input bit vs,
                              input int r, input int g, input int b);
        bit bfall;
        bit hfall;
        bit vfall;
        bit werr;
        int height;
        bfall  = m_pb && !bl;
        hfall  = m_ph && !hs;
        vfall  = m_pvs && !vs;
        exp_pv = 1'b0;
        exp_fs = 1'b0;
        exp_se = 1'b0;
        werr   = bfall && (m_x != H_ACT);
        if (bl) begin
            exp_cx = m_x; exp_cy = m_y;
            exp_r = r; exp_g = g; exp_b = b;
            exp_pv = m_locked;
            exp_fs = m_locked && (m_x == 0) && (m_y == 0);
            m_x = (m_x < MAXC) ? m_x + 1 : MAXC;
        end
        if (hfall) m_x = 0;
        if (bfall) begin
            m_x = 0;
            m_y = (m_y < MAXC) ? m_y + 1 : MAXC;
        end
        height = m_y;
        if (vfall) begin
            m_x = 0;
            m_y = 0;
        end
        if (m_locked || m_aligned) begin
            if (werr) begin
                m_locked = 1'b0; m_aligned = 1'b0; exp_se = 1'b1;
            end else if (vfall) begin
                if (height == V_ACT) begin
                    m_locked = 1'b1; m_aligned = 1'b0;
                end else begin
                    m_locked = 1'b0; m_aligned = 1'b0; exp_se = 1'b1;
                end
            end
        end else if (vfall) begin
            m_aligned = 1'b1;
        end
        exp_lock = m_locked;
        m_pb = bl; m_ph = hs; m_pvs = vs;
    endtask

    task automatic check_output();
        check_val("coord_x",     32'(CoordX),     32'(exp_cx));
        check_val("coord_y",     32'(CoordY),     32'(exp_cy));
        check_val("r_out",       32'(ROut),       32'(exp_r));
        check_val("g_out",       32'(GOut),       32'(exp_g));
        check_val("b_out",       32'(BOut),       32'(exp_b));
        check_val("pixel_valid", 32'(PixelValid), 32'(exp_pv));
        check_val("frame_start", 32'(FrameStart), 32'(exp_fs));
        check_val("locked",      32'(Locked),     32'(exp_lock));
        check_val("sync_error",  32'(SyncError),  32'(exp_se));
        if (PixelValid === 1'b1) pv_seen++;
        if (FrameStart === 1'b1) fs_seen++;
        if (SyncError === 1'b1) se_seen++;
    endtask

    // Drive one clock cycle of inputs at the falling edge and check after the next rise.
    task automatic apply_stimulus(input bit en, input bit bl, input bit hs, input bit vs,
                                  input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        PixEn = en; Blank = bl; Hsync = hs; Vsync = vs; R = r; G = g; B = b;
        @(posedge Clock50Mhz);
        if (en) begin
            model_step(bl, hs, vs, int'(r), int'(g), int'(b));
        end else begin
            exp_pv = 1'b0; exp_fs = 1'b0; exp_se = 1'b0;
        end
        @(negedge Clock50Mhz);
        check_output();
    endtask

    // One sampled value, preceded by PixEn-low cycles carrying junk on the inputs.
    task automatic send_sample(input bit bl, input bit hs, input bit vs,
                               input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int gaps;
        gaps = $urandom_range(gap_max, gap_min);
        for (int i = 0; i < gaps; i++) begin
            apply_stimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                           8'($urandom), 8'($urandom), 8'($urandom));
        end
        apply_stimulus(1'b1, bl, hs, vs, r, g, b);
    endtask

    task automatic send_blank(input bit hs, input bit vs);
        send_sample(1'b0, hs, vs, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // Lines of active video each followed by blanking, then a vertical sync period.
    // bad_line gets bad_w pixels; merged puts the Vsync fall on the last Blank fall.
    task automatic send_frame(input int lines, input int bad_line, input int bad_w, input bit merged);
        int w;
        for (int l = 0; l < lines; l++) begin
            w = (l == bad_line) ? bad_w : H_ACT;
            for (int p = 0; p < w; p++) begin
                send_sample(1'b1, 1'b1, 1'b1, 8'(p), 8'(l), 8'($urandom));
            end
            if (merged && (l == lines - 1)) begin
                send_blank(1'b1, 1'b0);
                send_blank(1'b0, 1'b0);
                send_blank(1'b1, 1'b0);
                send_blank(1'b1, 1'b1);
            end else begin
                send_blank(1'b1, 1'b1);
                send_blank(1'b0, 1'b1);
                send_blank(1'b0, 1'b1);
                send_blank(1'b1, 1'b1);
            end
        end
        if (!merged) begin
            send_blank(1'b1, 1'b0);
            send_blank(1'b0, 1'b0);
            send_blank(1'b1, 1'b0);
            send_blank(1'b1, 1'b1);
        end
    endtask

    task automatic clear_seen();
        pv_seen = 0; fs_seen = 0; se_seen = 0;
    endtask

    initial begin
        int lines;
        int bad_line;
        int bad_w;
        bit merged;

        $display("[TB] start");
        PixEn = 1'b0; Blank = 1'b1; Hsync = 1'b1; Vsync = 1'b1;
        R = '0; G = '0; B = '0;
        Reset = 1'b0;
        model_reset();
        #12;
        check_output();
        @(negedge Clock50Mhz);
        Reset = 1'b1;

        // Scenario 1: three clean frames, lock after the second Vsync fall.
        send_frame(V_ACT, -1, 0, 1'b0);
        check_val("s1_unlocked_after_f1", 32'(Locked), 32'd0);
        send_frame(V_ACT, -1, 0, 1'b0);
        check_val("s1_locked_after_f2", 32'(Locked), 32'd1);
        clear_seen();
        send_frame(V_ACT, -1, 0, 1'b0);
        check_val("s1_pv_count", 32'(pv_seen), 32'd32);
        check_val("s1_fs_count", 32'(fs_seen), 32'd1);

        // Scenario 2: one 9-pixel line breaks lock; relock two frames later.
        clear_seen();
        send_frame(V_ACT, 1, 9, 1'b0);
        check_val("s2_se_count", 32'(se_seen), 32'd1);
        check_val("s2_unlocked", 32'(Locked), 32'd0);
        clear_seen();
        send_frame(V_ACT, -1, 0, 1'b0);
        check_val("s2_no_pv_while_align", 32'(pv_seen), 32'd0);
        check_val("s2_relocked", 32'(Locked), 32'd1);

        // Scenario 3: five-line frame fails height check.
        clear_seen();
        send_frame(5, -1, 0, 1'b0);
        check_val("s3_se_count", 32'(se_seen), 32'd1);
        check_val("s3_unlocked", 32'(Locked), 32'd0);
        send_frame(V_ACT, -1, 0, 1'b0);
        send_frame(V_ACT, -1, 0, 1'b0);
        check_val("s3_relocked", 32'(Locked), 32'd1);

        // Scenario 4: Blank and Vsync fall together on the last line.
        clear_seen();
        send_frame(V_ACT, -1, 0, 1'b1);
        check_val("s4_still_locked", 32'(Locked), 32'd1);
        check_val("s4_no_error", 32'(se_seen), 32'd0);
        check_val("s4_pv_count", 32'(pv_seen), 32'd32);

        // Scenario 5: irregular PixEn gaps with data following the pixel index.
        gap_min = 0; gap_max = 3;
        clear_seen();
        send_frame(V_ACT, -1, 0, 1'b0);
        send_frame(V_ACT, -1, 0, 1'b1);
        check_val("s5_pv_count", 32'(pv_seen), 32'd64);
        check_val("s5_fs_count", 32'(fs_seen), 32'd2);

        // Scenario 6: asynchronous reset in the middle of a frame.
        gap_min = 1; gap_max = 1;
        for (int p = 0; p < 5; p++) begin
            send_sample(1'b1, 1'b1, 1'b1, 8'(p), 8'd0, 8'($urandom));
        end
        #2;
        Reset = 1'b0;
        model_reset();
        #1;
        check_output();
        @(negedge Clock50Mhz);
        PixEn = 1'b0;
        Reset = 1'b1;
        send_frame(V_ACT, -1, 0, 1'b0);
        check_val("s6_unlocked_after_f1", 32'(Locked), 32'd0);
        send_frame(V_ACT, -1, 0, 1'b0);
        check_val("s6_relocked", 32'(Locked), 32'd1);

        // Randomized frames: geometry faults and gaps chosen at random.
        gap_min = 0; gap_max = 2;
        for (int f = 0; f < 12; f++) begin
            lines    = ($urandom_range(3, 0) == 0) ? int'($urandom_range(5, 3)) : V_ACT;
            bad_line = ($urandom_range(3, 0) == 0) ? int'($urandom_range(lines - 1, 0)) : -1;
            bad_w    = ($urandom_range(1, 0) == 0) ? H_ACT - 1 : H_ACT + 1;
            merged   = 1'($urandom);
            send_frame(lines, bad_line, bad_w, merged);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
